// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request, MTHI/MTLO and result bundle for the sequential multiply/divide unit
interface muldiv_seq_if;
  logic        start, op, flush, wr_hi, wr_lo;
  logic [31:0] rs_val, rt_val, wr_data;
  logic        stall_req, busy, done, div_by_zero;
  logic [31:0] hi, lo;
  modport master (
    output start, op, rs_val, rt_val, flush, wr_hi, wr_lo, wr_data,
    input  stall_req, busy, done, div_by_zero, hi, lo
  );
  modport slave (
    input  start, op, rs_val, rt_val, flush, wr_hi, wr_lo, wr_data,
    output stall_req, busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: 32-cycle MULTU/DIVU unit owning the architectural HI/LO registers
module muldiv_seq (
  input logic            clk,
  input logic            Rst,
  muldiv_seq_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic        dbz_q, dbz_d;
  logic [32:0] add, rem, diff;
  logic        accept, last;
  always_comb begin
    accept  = state_q == IDLE && bus.start && !bus.flush;
    last    = cnt_q == 6'd31;
    add     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    rem     = {acc_q[63:32], acc_q[31]};
    diff    = rem - {1'b0, b_q};
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = bus.op ? DIV : MUL;
          cnt_d   = 6'd0;
          acc_d   = {32'd0, bus.op ? bus.rs_val : bus.rt_val};
          b_d     = bus.op ? bus.rt_val : bus.rs_val;
        end else if (!bus.start) begin
          hi_d = bus.wr_hi ? bus.wr_data : hi_q;
          lo_d = bus.wr_lo ? bus.wr_data : lo_q;
        end
      end
      MUL, DIV: begin
        // a borrow out of the 33-bit subtract means the divisor did not fit: restore
        acc_d   = state_q == MUL ? {add, acc_q[31:1]}
                                 : {diff[32] ? rem[31:0] : diff[31:0], acc_q[30:0], ~diff[32]};
        cnt_d   = cnt_q + 6'd1;
        state_d = bus.flush ? IDLE : last ? DONE : state_q;
        if (!bus.flush && last) begin
          hi_d  = acc_d[63:32];
          lo_d  = acc_d[31:0];
          dbz_d = state_q == DIV ? b_q == 32'd0 : dbz_q;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      acc_q   <= 64'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end
  assign bus.busy        = state_q == MUL || state_q == DIV;
  assign bus.done        = state_q == DONE;
  assign bus.stall_req   = bus.busy || (state_q == IDLE && bus.start && (bus.wr_hi || bus.wr_lo));
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: random and directed MULTU/DIVU traffic checked against an arithmetic model
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic Rst;
  always #5 clk = ~clk;
  muldiv_seq_if bus();
  muldiv_seq dut (.clk(clk), .Rst(Rst), .bus(bus));
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  int          m_left = 0;
  bit          m_done = 0, m_dbz = 0, p_dbz = 0, p_div = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // reference: results computed with plain arithmetic at acceptance, released 32 edges later
  always @(posedge clk) begin : model
    logic [63:0] p;
    if (Rst) begin
      m_left = 0; m_done = 0; m_hi = 0; m_lo = 0; m_dbz = 0; chk_en = 1;
    end else if (m_done) m_done = 0;
    else if (m_left > 0) begin
      if (bus.flush) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1;
          if (p_div) m_dbz = p_dbz;
        end
      end
    end else if (bus.start && !bus.flush) begin
      m_left = 32;
      p_div  = bus.op;
      if (bus.op) begin
        p_dbz = bus.rt_val == 0;
        if (p_dbz) begin p_lo = '1; p_hi = bus.rs_val; end
        else begin p_lo = bus.rs_val / bus.rt_val; p_hi = bus.rs_val % bus.rt_val; end
      end else begin
        p = 64'(bus.rs_val) * 64'(bus.rt_val);
        p_hi = p[63:32]; p_lo = p[31:0];
      end
    end else if (!bus.start) begin
      if (bus.wr_hi) m_hi = bus.wr_data;
      if (bus.wr_lo) m_lo = bus.wr_data;
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("busy",  32'(bus.busy), 32'(m_left > 0));
    chk("done",  32'(bus.done), 32'(m_done));
    chk("stall", 32'(bus.stall_req), 32'(m_left > 0 ||
        (!m_done && m_left == 0 && bus.start && (bus.wr_hi || bus.wr_lo))));
    chk("dbz",   32'(bus.div_by_zero), 32'(m_dbz));
    chk("hi",    bus.hi, m_hi);
    chk("lo",    bus.lo, m_lo);
  end
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed);
    bus.op = o; bus.rs_val = a; bus.rt_val = b; bus.start = 1; cyc();
    bus.start = 0; bus.rs_val = ~a; bus.rt_val = b + 32'd1;
    @(negedge clk);
    chk("lit_stall_busy", 32'(bus.stall_req), 32'd1);
    for (int i = 0; i < 32; i++) begin
      bus.start = (i == 5); bus.op = ~o;
      bus.wr_hi = (i == 9); bus.wr_data = 32'hDEADBEEF;
      cyc();
    end
    bus.start = 0; bus.wr_hi = 0;
    @(negedge clk);
    chk("lit_done",  32'(bus.done), 32'd1);
    chk("lit_stall_done", 32'(bus.stall_req), 32'd0);
    chk("lit_hi",    bus.hi, eh);
    chk("lit_lo",    bus.lo, el);
    chk("lit_dbz",   32'(bus.div_by_zero), 32'(ed));
    cyc();
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction
  initial begin
    bus.start = 0; bus.op = 0; bus.rs_val = 0; bus.rt_val = 0; bus.flush = 0;
    bus.wr_hi = 0; bus.wr_lo = 0; bus.wr_data = 0;
    Rst = 1; cyc(); cyc(); Rst = 0;
    @(negedge clk);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_stall", 32'(bus.stall_req), 32'd0);
    chk("rst_hi",    bus.hi, 32'd0);
    chk("rst_lo",    bus.lo, 32'd0);
    cyc();
    run_op(1'b0, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0);
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0);
    run_op(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op(1'b1, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 1'b1);
    bus.wr_hi = 1; bus.wr_data = 32'hAAAAAAAA; cyc();
    bus.wr_hi = 0; bus.wr_lo = 1; bus.wr_data = 32'h55555555; cyc();
    bus.wr_lo = 0;
    bus.op = 0; bus.rs_val = 32'd3; bus.rt_val = 32'd5; bus.start = 1; cyc();
    bus.start = 0; repeat (9) cyc();
    bus.flush = 1; cyc(); bus.flush = 0;
    @(negedge clk);
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_hi",   bus.hi, 32'hAAAAAAAA);
    chk("flush_lo",   bus.lo, 32'h55555555);
    repeat (30) cyc();
    @(negedge clk);
    chk("flush_nodone", 32'(bus.done), 32'd0);
    bus.op = 1; bus.rs_val = 32'd50; bus.rt_val = 32'd3; bus.start = 1; cyc();
    bus.start = 0; repeat (4) cyc();
    Rst = 1; cyc(); Rst = 0;
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_hi",   bus.hi, 32'd0);
    chk("midrst_lo",   bus.lo, 32'd0);
    run_op(1'b0, 32'd12, 32'd13, 32'd0, 32'd156, 1'b0);
    for (int i = 0; i < 5000; i++) begin
      bus.start   = $urandom_range(0, 3) == 0;
      bus.op      = 1'($urandom);
      bus.rs_val  = pick();
      bus.rt_val  = pick();
      bus.flush   = $urandom_range(0, 39) == 0;
      bus.wr_hi   = $urandom_range(0, 5) == 0;
      bus.wr_lo   = $urandom_range(0, 5) == 0;
      bus.wr_data = $urandom;
      Rst         = $urandom_range(0, 599) == 0;
      cyc();
    end
    Rst = 0; bus.start = 0; bus.flush = 0; bus.wr_hi = 0; bus.wr_lo = 0;
    repeat (40) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 The block SHALL have port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port start, input, 1 bit: issue request from EX stage for a MULTU/DIVU instruction.
REQ-004 The block SHALL have port op, input, 1 bit: 0 = MULTU, 1 = DIVU; sampled with start.
REQ-005 The block SHALL have port rs_val, input, 32 bits: multiplicand or dividend; sampled with start.
REQ-006 The block SHALL have port rt_val, input, 32 bits: multiplier or divisor; sampled with start.
REQ-007 The block SHALL have port flush, input, 1 bit: pipeline flush from branch/jump; aborts the operation in flight.
REQ-008 The block SHALL have ports wr_hi and wr_lo, input, 1 bit each, plus wr_data, input, 32 bits: MTHI/MTLO write port.
REQ-009 The block SHALL have port stall_req, output, 1 bit: stall request to the hazard unit for PC, IF_ID and ID_EX.
REQ-010 The block SHALL have port busy, output, 1 bit: high while the state is MUL or DIV.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when a result is committed.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit: high when the last committed DIVU had rt_val = 0.
REQ-013 The block SHALL have ports hi and lo, output, 32 bits each: architectural HI/LO registers.

Function
REQ-014 The FSM SHALL have states IDLE, MUL, DIV and DONE.
REQ-015 Transitions SHALL be:
- IDLE -> MUL on start && !flush && op=0.
- IDLE -> DIV on start && !flush && op=1.
- MUL/DIV -> DONE after 32 iterations.
- MUL/DIV -> IDLE on flush.
- DONE -> IDLE unconditionally.
REQ-016 start SHALL be accepted only in IDLE; start in MUL, DIV or DONE SHALL be ignored.
REQ-017 A 6-bit iteration counter SHALL load 0 on acceptance, increment once per cycle in MUL/DIV, and leave on the cycle it reaches 31.
REQ-018 MUL SHALL perform unsigned shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
REQ-019 DIV SHALL perform restoring unsigned division, one quotient bit per cycle, with a 33-bit partial-remainder subtract.
REQ-020 Latency: start accepted at edge N; done = 1 and hi/lo updated during cycle N+33 (state DONE).
REQ-021 Commit on MULTU: hi = product[63:32], lo = product[31:0].
REQ-022 Commit on DIVU: lo = quotient, hi = remainder.
REQ-023 DIVU with rt_val = 0 SHALL run the full 32 iterations and commit lo = 0xFFFFFFFF, hi = rs_val, div_by_zero = 1.
REQ-024 div_by_zero SHALL update only at a DIVU commit and hold until the next DIVU commit.
REQ-025 stall_req SHALL be combinational: high in MUL and DIV, and high in IDLE when (wr_hi || wr_lo) coincides with start.
REQ-026 stall_req SHALL be low in DONE so that MFHI/MFLO in ID sees committed values next cycle.
REQ-027 flush in MUL/DIV SHALL return the FSM to IDLE next edge, leave hi/lo/div_by_zero unchanged, and produce no done pulse.
REQ-028 flush during DONE SHALL NOT cancel the commit.
REQ-029 wr_hi/wr_lo SHALL write hi/lo from wr_data only in IDLE, when start is low.
REQ-030 wr_hi/wr_lo in any other state SHALL be ignored.
REQ-031 Operand registers SHALL be captured at acceptance; changes on rs_val/rt_val afterwards SHALL NOT affect the result.

Reset
REQ-032 On Rst = 1 at a rising edge, the state SHALL be IDLE, and counter, accumulator, hi, lo, div_by_zero and done SHALL be 0.
REQ-033 Rst SHALL take priority over start, flush and wr_hi/wr_lo, including mid-operation.
REQ-034 stall_req and busy SHALL be 0 in the cycle after reset is applied.

Verification
REQ-035 MULTU rs=7, rt=6 -> stall_req high cycles N+1..N+32, done at N+33, hi=0x00000000, lo=0x0000002A.
REQ-036 MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 DIVU rs=100, rt=7 -> lo=14, hi=2, div_by_zero=0; then DIVU rs=0x12345678, rt=0 -> lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1.
REQ-038 Preload hi=0xAAAAAAAA, lo=0x55555555 via wr_hi/wr_lo; start MULTU; flush at N+10 -> IDLE at N+11, no done, hi/lo unchanged.
REQ-039 Start DIVU, assert Rst at N+5 -> IDLE, hi=lo=0, busy=0 next cycle; start pulsed during MUL is ignored and the first result is unaffected.
